// File: rtl/seven_segment_scanner_if.sv
// Purpose : bundles the display data inputs and the segment/anode outputs of
//           seven_segment_scanner into one interface.
// Signals : val_in/dp_in/blank_in/blink_in  per-digit content (buffered by the scanner)
//           lz_en_in/bright_in               live display controls
//           update_in                        capture content into the pending buffer
//           cat_out/dp_out/an_out            active-low segment, dp and anode drives
//           frame_out                        one-cycle pulse at each frame boundary
// Modports: master drives content and observes the display; slave is the scanner.
interface seven_segment_scanner_if #(
    parameter int unsigned NUM_DIGITS = 8,
    parameter int unsigned BRIGHT_W   = 4
);
    logic [4*NUM_DIGITS-1:0] val_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   blank_in;
    logic [NUM_DIGITS-1:0]   blink_in;
    logic                    lz_en_in;
    logic [BRIGHT_W-1:0]     bright_in;
    logic                    update_in;
    logic [6:0]              cat_out;
    logic                    dp_out;
    logic [NUM_DIGITS-1:0]   an_out;
    logic                    frame_out;

    modport master (
        output val_in, dp_in, blank_in, blink_in, lz_en_in, bright_in, update_in,
        input  cat_out, dp_out, an_out, frame_out
    );

    modport slave (
        input  val_in, dp_in, blank_in, blink_in, lz_en_in, bright_in, update_in,
        output cat_out, dp_out, an_out, frame_out
    );
endinterface

// File: rtl/seven_segment_scanner.sv
// Purpose : multiplexed NUM_DIGITS hex seven-segment driver with per-digit dp,
//           blank and blink, leading-zero suppression, PWM brightness and a
//           double-buffered content update that only takes effect at a frame
//           boundary.
// Ports   : clk_in  system clock
//           rst_in  synchronous active-high reset
//           bus     seven_segment_scanner_if.slave (content in, display drives out)
module seven_segment_scanner #(
    parameter int unsigned NUM_DIGITS   = 8,
    parameter int unsigned COUNT_TO     = 100000,
    parameter int unsigned BRIGHT_W     = 4,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    seven_segment_scanner_if.slave bus
);
    localparam int unsigned SLOT_W  = $clog2(COUNT_TO);
    localparam int unsigned DIG_W   = $clog2(NUM_DIGITS);
    localparam int unsigned FRAME_W = $clog2(BLINK_FRAMES);
    localparam int unsigned VAL_W   = 4 * NUM_DIGITS;

    localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(COUNT_TO - 1);
    localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
    localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);
    localparam logic [FRAME_W-1:0] FRAME_HALF = FRAME_W'(BLINK_FRAMES / 2);

    // Active-high segment pattern {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_font(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h00;
        case (nib)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            4'hF: seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

    logic [SLOT_W-1:0]     r_slot_cnt;
    logic [DIG_W-1:0]      r_digit;
    logic [FRAME_W-1:0]    r_frame_cnt;
    logic [VAL_W-1:0]      r_pend_val,   r_act_val;
    logic [NUM_DIGITS-1:0] r_pend_dp,    r_act_dp;
    logic [NUM_DIGITS-1:0] r_pend_blank, r_act_blank;
    logic [NUM_DIGITS-1:0] r_pend_blink, r_act_blink;
    logic [NUM_DIGITS-1:0] r_an;
    logic [6:0]            r_cat;
    logic                  r_dp;
    logic                  r_frame;

    logic                  w_slot_wrap;
    logic                  w_frame_bound;
    logic                  w_pwm_on;
    logic                  w_blink_phase;
    logic                  w_zero_above;
    logic [NUM_DIGITS-1:0] w_lz_sup;
    logic [3:0]            w_nib;
    logic                  w_sel_dp, w_sel_blank, w_sel_blink, w_sel_lz;
    logic                  w_visible;
    logic [NUM_DIGITS-1:0] w_an_c;
    logic [6:0]            w_cat_c;
    logic                  w_dp_c;

    assign w_slot_wrap   = (r_slot_cnt == SLOT_LAST);
    assign w_frame_bound = w_slot_wrap & (r_digit == DIG_LAST);
    assign w_blink_phase = (r_frame_cnt >= FRAME_HALF);
    assign w_pwm_on      = (bus.bright_in == {BRIGHT_W{1'b1}}) |
                           (r_slot_cnt[BRIGHT_W-1:0] < bus.bright_in);

    // Slot, digit and frame counters
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_slot_cnt  <= '0;
            r_digit     <= '0;
            r_frame_cnt <= '0;
        end else if (w_slot_wrap) begin
            r_slot_cnt <= '0;
            r_digit    <= (r_digit == DIG_LAST) ? '0 : r_digit + DIG_W'(1);
            if (w_frame_bound)
                r_frame_cnt <= (r_frame_cnt == FRAME_LAST) ? '0 : r_frame_cnt + FRAME_W'(1);
        end else begin
            r_slot_cnt <= r_slot_cnt + SLOT_W'(1);
        end
    end

    // Pending buffer: last update in a frame wins
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '1;
            r_pend_blink <= '0;
        end else if (bus.update_in) begin
            r_pend_val   <= bus.val_in;
            r_pend_dp    <= bus.dp_in;
            r_pend_blank <= bus.blank_in;
            r_pend_blink <= bus.blink_in;
        end
    end

    // Active buffer only changes at the frame boundary; a same-cycle update bypasses pending
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_act_val   <= '0;
            r_act_dp    <= '0;
            r_act_blank <= '1;
            r_act_blink <= '0;
        end else if (w_frame_bound) begin
            r_act_val   <= bus.update_in ? bus.val_in   : r_pend_val;
            r_act_dp    <= bus.update_in ? bus.dp_in    : r_pend_dp;
            r_act_blank <= bus.update_in ? bus.blank_in : r_pend_blank;
            r_act_blink <= bus.update_in ? bus.blink_in : r_pend_blink;
        end
    end

    // Leading-zero map: digit i>0 suppressed when it and every digit above it are zero
    always_comb begin
        w_zero_above = 1'b1;
        w_lz_sup     = '0;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            w_zero_above = w_zero_above & (r_act_val[4*i +: 4] == 4'h0);
            w_lz_sup[i]  = bus.lz_en_in & w_zero_above & (i != 0);
        end
    end

    // Select the scanned digit's attributes and form the next display drive
    always_comb begin
        w_nib       = 4'h0;
        w_sel_dp    = 1'b0;
        w_sel_blank = 1'b1;
        w_sel_blink = 1'b0;
        w_sel_lz    = 1'b0;
        w_an_c      = '1;
        w_cat_c     = 7'h7F;
        w_dp_c      = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (DIG_W'(i) == r_digit) begin
                w_nib       = r_act_val[4*i +: 4];
                w_sel_dp    = r_act_dp[i];
                w_sel_blank = r_act_blank[i];
                w_sel_blink = r_act_blink[i];
                w_sel_lz    = w_lz_sup[i];
            end
        end
        w_visible = ~w_sel_blank & ~(w_sel_blink & w_blink_phase) & w_pwm_on;
        if (w_visible) begin
            if (!w_sel_lz) begin
                w_an_c  = ~(NUM_DIGITS'(1) << r_digit);
                w_cat_c = ~hex_font(w_nib);
                w_dp_c  = ~w_sel_dp;
            end else if (w_sel_dp) begin
                // Suppressed digit keeps its decimal point with segments dark
                w_an_c  = ~(NUM_DIGITS'(1) << r_digit);
                w_cat_c = 7'h7F;
                w_dp_c  = 1'b0;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_an    <= '1;
            r_cat   <= 7'h7F;
            r_dp    <= 1'b1;
            r_frame <= 1'b0;
        end else begin
            r_an    <= w_an_c;
            r_cat   <= w_cat_c;
            r_dp    <= w_dp_c;
            r_frame <= w_frame_bound;
        end
    end

    assign bus.an_out    = r_an;
    assign bus.cat_out   = r_cat;
    assign bus.dp_out    = r_dp;
    assign bus.frame_out = r_frame;
endmodule

// File: tb/tb_seven_segment_scanner.sv
// Purpose: directed self-checking bench for seven_segment_scanner with
//          NUM_DIGITS=4, COUNT_TO=16, BRIGHT_W=2, BLINK_FRAMES=4 (64-cycle frames).
module tb_seven_segment_scanner;
    localparam int unsigned ND = 4;
    localparam int unsigned CT = 16;
    localparam int unsigned BW = 2;
    localparam int unsigned BF = 4;

    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulse_cnt = 0;

    // Captured frame: index j is scan state j (digit j/16, slot j%16)
    logic [3:0] cap_an  [64];
    logic [6:0] cap_cat [64];
    logic       cap_dp  [64];
    logic       cap_fr  [64];
    int         cap_frame_no;
    bit         cap_ok;

    // Active-high {g,f,e,d,c,b,a} patterns for 0..F
    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [3:0] an_tab  [4]  = '{4'hE, 4'hD, 4'hB, 4'h7};

    seven_segment_scanner_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW)) bus ();

    seven_segment_scanner #(
        .NUM_DIGITS(ND), .COUNT_TO(CT), .BRIGHT_W(BW), .BLINK_FRAMES(BF)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Frames since reset; the DUT frame counter equals this mod BLINK_FRAMES
    always @(posedge clk) begin
        if (rst) pulse_cnt <= 0;
        else if (bus.frame_out === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Sample one full frame starting at the current or next frame_out pulse
    task automatic capture_frame();
        int guard;
        guard  = 0;
        cap_ok = 1'b1;
        while (bus.frame_out !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (bus.frame_out !== 1'b1) begin
            cap_ok = 1'b0;
            return;
        end
        for (int j = 0; j < 64; j++) begin
            @(negedge clk);
            cap_an[j]  = bus.an_out;
            cap_cat[j] = bus.cat_out;
            cap_dp[j]  = bus.dp_out;
            cap_fr[j]  = bus.frame_out;
            if (j == 0) cap_frame_no = pulse_cnt % 4;
        end
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] blank,
                        input logic [3:0] blink);
        bus.val_in    = v;
        bus.dp_in     = dp;
        bus.blank_in  = blank;
        bus.blink_in  = blink;
        bus.update_in = 1'b1;
        @(negedge clk);
        bus.update_in = 1'b0;
    endtask

    task automatic test_reset();
        int bad_an, pulses, bad_pos;
        rst           = 1'b1;
        bus.val_in    = '0;
        bus.dp_in     = '0;
        bus.blank_in  = '0;
        bus.blink_in  = '0;
        bus.lz_en_in  = 1'b0;
        bus.bright_in = 2'd3;
        bus.update_in = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.an_out !== 4'hF) begin n_bad++; $display("FAIL reset_an: got %h exp F", bus.an_out); end
        n_cmp++; if (bus.cat_out !== 7'h7F) begin n_bad++; $display("FAIL reset_cat: got %h exp 7f", bus.cat_out); end
        n_cmp++; if (bus.dp_out !== 1'b1) begin n_bad++; $display("FAIL reset_dp: got %b exp 1", bus.dp_out); end
        n_cmp++; if (bus.frame_out !== 1'b0) begin n_bad++; $display("FAIL reset_frame: got %b exp 0", bus.frame_out); end
        rst = 1'b0;
        bad_an = 0; pulses = 0; bad_pos = 0;
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (bus.an_out !== 4'hF) bad_an++;
            if (bus.frame_out === 1'b1) begin
                pulses++;
                if (n % 64 != 0) bad_pos++;
            end
        end
        n_cmp++; if (bad_an != 0) begin n_bad++; $display("FAIL idle_dark: %0d lit cycles exp 0", bad_an); end
        n_cmp++; if (pulses != 3) begin n_bad++; $display("FAIL idle_pulses: got %0d exp 3", pulses); end
        n_cmp++; if (bad_pos != 0) begin n_bad++; $display("FAIL idle_pulse_period: %0d misplaced exp 0", bad_pos); end
    endtask

    task automatic test_display();
        logic [15:0] v;
        logic [3:0]  nib;
        v = 16'h12AF;
        load(v, 4'h0, 4'h0, 4'h0);
        capture_frame();
        n_cmp++; if (!cap_ok) begin n_bad++; $display("FAIL display_wait: got timeout exp pulse"); end
        for (int j = 0; j < 64; j++) begin
            nib = v[4*(j/16) +: 4];
            n_cmp++; if (cap_an[j] !== an_tab[j/16]) begin n_bad++; $display("FAIL display_an[%0d]: got %h exp %h", j, cap_an[j], an_tab[j/16]); end
            n_cmp++; if (cap_cat[j] !== ~seg_tab[nib]) begin n_bad++; $display("FAIL display_cat[%0d]: got %h exp %h", j, cap_cat[j], ~seg_tab[nib]); end
            n_cmp++; if (cap_dp[j] !== 1'b1) begin n_bad++; $display("FAIL display_dp[%0d]: got %b exp 1", j, cap_dp[j]); end
            n_cmp++; if (cap_fr[j] !== (j == 63)) begin n_bad++; $display("FAIL display_frame[%0d]: got %b exp %b", j, cap_fr[j], j == 63); end
        end
    endtask

    task automatic test_font();
        logic [15:0] vals [4] = '{16'h0123, 16'h4567, 16'h89AB, 16'hCDEF};
        logic [15:0] v;
        logic [3:0]  nib;
        for (int f = 0; f < 4; f++) begin
            v = vals[f];
            load(v, 4'h0, 4'h0, 4'h0);
            capture_frame();
            n_cmp++; if (!cap_ok) begin n_bad++; $display("FAIL font_wait: got timeout exp pulse"); end
            for (int d = 0; d < 4; d++) begin
                nib = v[4*d +: 4];
                n_cmp++; if (cap_an[d*16+8] !== an_tab[d]) begin n_bad++; $display("FAIL font_an %h: got %h exp %h", nib, cap_an[d*16+8], an_tab[d]); end
                n_cmp++; if (cap_cat[d*16+8] !== ~seg_tab[nib]) begin n_bad++; $display("FAIL font_cat %h: got %h exp %h", nib, cap_cat[d*16+8], ~seg_tab[nib]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] v;
        logic [3:0]  nib;
        v = 16'h12AF;
        load(v, 4'h0, 4'h0, 4'h0);
        capture_frame();
        n_cmp++; if (!cap_ok) begin n_bad++; $display("FAIL b2b_wait: got timeout exp pulse"); end
        for (int k = 1; k <= 63; k++) begin
            @(negedge clk);
            nib = v[4*((k-1)/16) +: 4];
            n_cmp++; if (bus.an_out !== an_tab[(k-1)/16]) begin n_bad++; $display("FAIL b2b_hold_an[%0d]: got %h exp %h", k, bus.an_out, an_tab[(k-1)/16]); end
            n_cmp++; if (bus.cat_out !== ~seg_tab[nib]) begin n_bad++; $display("FAIL b2b_hold_cat[%0d]: got %h exp %h", k, bus.cat_out, ~seg_tab[nib]); end
            if (k == 20) begin bus.val_in = 16'h1111; bus.update_in = 1'b1; end
            if (k == 21) bus.update_in = 1'b0;
            if (k == 26) begin bus.val_in = 16'h2222; bus.update_in = 1'b1; end
            if (k == 27) bus.update_in = 1'b0;
        end
        capture_frame();
        n_cmp++; if (!cap_ok) begin n_bad++; $display("FAIL b2b_wait2: got timeout exp pulse"); end
        for (int j = 0; j < 64; j++) begin
            n_cmp++; if (cap_an[j] !== an_tab[j/16]) begin n_bad++; $display("FAIL b2b_an[%0d]: got %h exp %h", j, cap_an[j], an_tab[j/16]); end
            n_cmp++; if (cap_cat[j] !== 7'h24) begin n_bad++; $display("FAIL b2b_cat[%0d]: got %h exp 24", j, cap_cat[j]); end
        end
    endtask

    task automatic test_leading_zero();
        logic [3:0] an_e  [4] = '{4'hE, 4'hD, 4'hF, 4'h7};
        logic [6:0] cat_e [4] = '{7'h40, 7'h12, 7'h7F, 7'h7F};
        logic       dp_e  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        bus.lz_en_in = 1'b1;
        load(16'h0050, 4'b1000, 4'h0, 4'h0);
        capture_frame();
        n_cmp++; if (!cap_ok) begin n_bad++; $display("FAIL lz_wait: got timeout exp pulse"); end
        for (int j = 0; j < 64; j++) begin
            n_cmp++; if (cap_an[j] !== an_e[j/16]) begin n_bad++; $display("FAIL lz_an[%0d]: got %h exp %h", j, cap_an[j], an_e[j/16]); end
            n_cmp++; if (cap_cat[j] !== cat_e[j/16]) begin n_bad++; $display("FAIL lz_cat[%0d]: got %h exp %h", j, cap_cat[j], cat_e[j/16]); end
            n_cmp++; if (cap_dp[j] !== dp_e[j/16]) begin n_bad++; $display("FAIL lz_dp[%0d]: got %b exp %b", j, cap_dp[j], dp_e[j/16]); end
        end
    endtask

    task automatic test_pwm();
        logic [3:0] an_e  [4] = '{4'hE, 4'hD, 4'hF, 4'h7};
        logic [3:0] exp_an;
        int lit0, lit_any;
        bus.bright_in = 2'd1;
        @(negedge clk);
        capture_frame();
        n_cmp++; if (!cap_ok) begin n_bad++; $display("FAIL pwm1_wait: got timeout exp pulse"); end
        lit0 = 0;
        for (int j = 0; j < 64; j++) begin
            exp_an = (j % 4 == 0) ? an_e[j/16] : 4'hF;
            if (j < 16 && cap_an[j] === 4'hE) lit0++;
            n_cmp++; if (cap_an[j] !== exp_an) begin n_bad++; $display("FAIL pwm1_an[%0d]: got %h exp %h", j, cap_an[j], exp_an); end
        end
        n_cmp++; if (lit0 != 4) begin n_bad++; $display("FAIL pwm1_duty: got %0d exp 4", lit0); end
        bus.bright_in = 2'd0;
        @(negedge clk);
        capture_frame();
        n_cmp++; if (!cap_ok) begin n_bad++; $display("FAIL pwm0_wait: got timeout exp pulse"); end
        lit_any = 0;
        for (int j = 0; j < 64; j++) if (cap_an[j] !== 4'hF) lit_any++;
        n_cmp++; if (lit_any != 0) begin n_bad++; $display("FAIL pwm0_dark: got %0d lit exp 0", lit_any); end
        bus.bright_in = 2'd3;
        bus.lz_en_in  = 1'b0;
    endtask

    task automatic test_blink();
        int lit0, lit1, exp0, first;
        load(16'h12AF, 4'h0, 4'h0, 4'b0001);
        first = 0;
        for (int f = 0; f < 4; f++) begin
            capture_frame();
            n_cmp++; if (!cap_ok) begin n_bad++; $display("FAIL blink_wait: got timeout exp pulse"); end
            if (f == 0) first = cap_frame_no;
            lit0 = 0; lit1 = 0;
            for (int j = 0; j < 16; j++) if (cap_an[j] === 4'hE) lit0++;
            for (int j = 16; j < 32; j++) if (cap_an[j] === 4'hD) lit1++;
            exp0 = (cap_frame_no < 2) ? 16 : 0;
            n_cmp++; if (lit0 != exp0) begin n_bad++; $display("FAIL blink_d0 frame %0d: got %0d exp %0d", cap_frame_no, lit0, exp0); end
            n_cmp++; if (lit1 != 16) begin n_bad++; $display("FAIL blink_d1 frame %0d: got %0d exp 16", cap_frame_no, lit1); end
            n_cmp++; if (cap_frame_no != (first + f) % 4) begin n_bad++; $display("FAIL blink_seq: got %0d exp %0d", cap_frame_no, (first + f) % 4); end
        end
    endtask

    task automatic test_reset_mid_frame();
        int lit, early;
        load(16'h12AF, 4'h0, 4'h0, 4'h0);
        capture_frame();
        repeat (10) @(negedge clk);
        load(16'h3333, 4'h0, 4'h0, 4'h0);
        repeat (14) @(negedge clk);
        n_cmp++; if (bus.an_out !== 4'hD) begin n_bad++; $display("FAIL rstmid_pre_an: got %h exp D", bus.an_out); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (bus.an_out !== 4'hF) begin n_bad++; $display("FAIL rstmid_an: got %h exp F", bus.an_out); end
        n_cmp++; if (bus.cat_out !== 7'h7F) begin n_bad++; $display("FAIL rstmid_cat: got %h exp 7f", bus.cat_out); end
        n_cmp++; if (bus.dp_out !== 1'b1) begin n_bad++; $display("FAIL rstmid_dp: got %b exp 1", bus.dp_out); end
        lit = 0; early = 0;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (bus.an_out !== 4'hF) lit++;
            if (n < 64 && bus.frame_out !== 1'b0) early++;
        end
        n_cmp++; if (bus.frame_out !== 1'b1) begin n_bad++; $display("FAIL rstmid_restart_pulse: got %b exp 1", bus.frame_out); end
        n_cmp++; if (early != 0) begin n_bad++; $display("FAIL rstmid_early_pulse: got %0d exp 0", early); end
        n_cmp++; if (lit != 0) begin n_bad++; $display("FAIL rstmid_dark: got %0d lit exp 0", lit); end
        capture_frame();
        lit = 0;
        for (int j = 0; j < 64; j++) if (cap_an[j] !== 4'hF) lit++;
        n_cmp++; if (lit != 0) begin n_bad++; $display("FAIL rstmid_pending_discarded: got %0d lit exp 0", lit); end
        load(16'h12AF, 4'h0, 4'h0, 4'h0);
        capture_frame();
        n_cmp++; if (!cap_ok) begin n_bad++; $display("FAIL rstmid_wait: got timeout exp pulse"); end
        n_cmp++; if (cap_an[0] !== 4'hE) begin n_bad++; $display("FAIL rstmid_first_digit: got %h exp E", cap_an[0]); end
        n_cmp++; if (cap_cat[0] !== 7'h0E) begin n_bad++; $display("FAIL rstmid_first_cat: got %h exp 0e", cap_cat[0]); end
    endtask

    initial begin
        test_reset();
        test_display();
        test_font();
        test_back_to_back();
        test_leading_zero();
        test_pwm();
        test_blink();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
